// File: rtl/riscv_v_reduct_accumulator.sv
// Folds the per-register reduction results (vredand/vredor/vredxor) of a
// vector register group into one scalar. Each beat carries one ALU result
// whose element 0 already holds that register's reduction. The folded
// element-0 value is emitted with byte valids on a valid/ready output.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   in_valid_i     beat offered
//   in_ready_o     beat accepted when in_valid_i && in_ready_o
//   in_first_i     first beat of a reduction
//   in_last_i      last beat of a reduction
//   in_op_i        00 AND, 01 OR, 10 XOR, 11 reserved (OR); sampled on first beat
//   in_osize_i     one-hot element size {128,64,32,16,8}; sampled on first beat
//   in_result_i    {data, byte_valid}
//   out_valid_o    final result available
//   out_ready_i    consumer accepts when out_valid_o && out_ready_i
//   out_result_o   {data, byte_valid}, element 0 only
//   busy_o         a reduction is in progress or a result is held
//   proto_err_o    sticky protocol error flag, cleared by reset only
module riscv_v_reduct_accumulator #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic                             in_first_i,
  input  logic                             in_last_i,
  input  logic [1:0]                       in_op_i,
  input  logic [4:0]                       in_osize_i,
  input  logic [DATA_WIDTH+NUM_BYTES-1:0]  in_result_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH+NUM_BYTES-1:0]  out_result_o,
  output logic                             busy_o,
  output logic                             proto_err_o
);

  localparam int unsigned RW = DATA_WIDTH + NUM_BYTES;

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    acc_vld_q, acc_vld_d;
  logic [2:0]              widx_q, widx_d;  // log2(W/8)
  logic [1:0]              op_q, op_d;
  logic [RW-1:0]           out_result_q, out_result_d;
  logic                    proto_err_q, proto_err_d;

  logic                    beat_acc;
  logic                    start;
  logic                    load_out;
  logic [2:0]              in_widx;
  logic [2:0]              widx_eff;
  logic [1:0]              op_eff;
  int unsigned             w_bits;
  logic [DATA_WIDTH-1:0]   dmask;
  logic [NUM_BYTES-1:0]    bmask;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [DATA_WIDTH-1:0]   data_m;
  logic                    in_active;
  logic [DATA_WIDTH-1:0]   folded;

  assign in_ready_o   = (state_q != StHold) | out_ready_i;
  assign out_valid_o  = (state_q == StHold);
  assign busy_o       = (state_q != StIdle);
  assign out_result_o = out_result_q;
  assign proto_err_o  = proto_err_q;

  assign beat_acc  = in_valid_i & in_ready_o;
  // In HOLD a beat is only accepted alongside out_ready, so any accepted
  // first beat begins a fresh reduction regardless of state.
  assign start     = beat_acc & in_first_i;
  assign in_data   = in_result_i[RW-1:NUM_BYTES];
  assign in_active = in_result_i[0];

  // Lowest set bit of the one-hot size wins; all-zero falls back to 8 bits.
  always_comb begin
    in_widx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (in_osize_i[i]) in_widx = 3'(i);
    end
  end

  assign widx_eff = start ? in_widx : widx_q;
  assign op_eff   = start ? in_op_i : op_q;
  assign w_bits   = 32'd8 << widx_eff;

  always_comb begin
    dmask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i < w_bits) dmask[i] = 1'b1;
    end
    bmask = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (i < (w_bits >> 3)) bmask[i] = 1'b1;
    end
  end

  assign data_m = in_data & dmask;

  always_comb begin
    unique case (op_eff)
      2'b00:   folded = acc_q & data_m;
      2'b10:   folded = acc_q ^ data_m;
      default: folded = acc_q | data_m;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_vld_d   = acc_vld_q;
    widx_d      = widx_q;
    op_d        = op_q;
    proto_err_d = proto_err_q;
    load_out    = 1'b0;

    if (state_q == StHold && out_ready_i) state_d = StIdle;

    if (beat_acc) begin
      if (in_first_i) begin
        // A first beat inside ACC abandons the running reduction.
        if (state_q == StAcc) proto_err_d = 1'b1;
        widx_d    = in_widx;
        op_d      = in_op_i;
        acc_d     = in_active ? data_m : '0;
        acc_vld_d = in_active;
        state_d   = in_last_i ? StHold : StAcc;
        load_out  = in_last_i;
      end else if (state_q == StAcc) begin
        if (in_active) begin
          acc_d     = acc_vld_q ? folded : data_m;
          acc_vld_d = 1'b1;
        end
        if (in_last_i) begin
          state_d  = StHold;
          load_out = 1'b1;
        end
      end else begin
        // Non-first beat with no reduction open: drop it.
        proto_err_d = 1'b1;
      end
    end

    out_result_d = out_result_q;
    if (load_out) out_result_d = {acc_d, bmask & {NUM_BYTES{acc_vld_d}}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      acc_vld_q    <= 1'b0;
      widx_q       <= 3'd0;
      op_q         <= 2'b00;
      out_result_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_vld_q    <= acc_vld_d;
      widx_q       <= widx_d;
      op_q         <= op_d;
      out_result_q <= out_result_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_riscv_v_reduct_accumulator.sv
module tb_riscv_v_reduct_accumulator;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic         in_last;
  logic [1:0]   in_op;
  logic [4:0]   in_osize;
  logic [143:0] in_result;
  logic         out_valid;
  logic         out_ready;
  logic [143:0] out_result;
  logic         busy;
  logic         proto_err;

  int checks = 0;
  int errors = 0;

  riscv_v_reduct_accumulator #(
    .DATA_WIDTH (128),
    .NUM_BYTES  (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_first_i   (in_first),
    .in_last_i    (in_last),
    .in_op_i      (in_op),
    .in_osize_i   (in_osize),
    .in_result_i  (in_result),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .busy_o       (busy),
    .proto_err_o  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one beat for exactly one clock edge; caller ensures in_ready is high.
  task automatic send_beat(input logic first, input logic last, input logic [1:0] op,
                           input logic [4:0] osize, input logic [127:0] data,
                           input logic [15:0] bv);
    in_first  = first;
    in_last   = last;
    in_op     = op;
    in_osize  = osize;
    in_result = {data, bv};
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err);
    end
    checks++;
    if (out_result !== 144'h0) begin
      errors++; $display("FAIL reset_out_result: got %h want 0", out_result);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_or();
    send_beat(1'b1, 1'b1, 2'b01, 5'b00001, {120'hABCDEF0123456789ABCDEF01234567, 8'h5A},
              16'hFFFF);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_valid: got valid=%b busy=%b want 1 1", out_valid, busy);
    end
    checks++;
    if (out_result !== {120'h0, 8'h5A, 16'h0001}) begin
      errors++; $display("FAIL single_result: got %h want %h", out_result,
                         {120'h0, 8'h5A, 16'h0001});
    end
    pop_result();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pop: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_and4();
    send_beat(1'b1, 1'b0, 2'b00, 5'b00100, {96'hFFFF0000FFFF0000FFFF0000, 32'hFFFF00FF},
              16'hFFFF);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL and4_acc_state: got busy=%b valid=%b want 1 0", busy, out_valid);
    end
    send_beat(1'b0, 1'b0, 2'b11, 5'b00001, {96'h123456789ABCDEF012345678, 32'h0F0F0FFF},
              16'hFFFF);
    send_beat(1'b0, 1'b0, 2'b10, 5'b10000, {96'hFFFFFFFFFFFFFFFFFFFFFFFF, 32'hFFFFFFF0},
              16'h00FF);
    send_beat(1'b0, 1'b1, 2'b01, 5'b00001, {96'h0, 32'h7FFFFFFF}, 16'h0001);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL and4_valid: got %b want 1", out_valid);
    end
    checks++;
    if (out_result !== {96'h0, 32'h0F0F00F0, 16'h000F}) begin
      errors++; $display("FAIL and4_result: got %h want %h", out_result,
                         {96'h0, 32'h0F0F00F0, 16'h000F});
    end
    pop_result();
  endtask

  task automatic test_xor_inactive();
    // Multi-bit osize: lowest set bit (16-bit) selects the width.
    send_beat(1'b1, 1'b0, 2'b10, 5'b11010, {112'h0, 16'h1234}, 16'hFFFF);
    send_beat(1'b0, 1'b0, 2'b00, 5'b00001, {112'h0, 16'hFFFF}, 16'hFFFE);
    send_beat(1'b0, 1'b1, 2'b00, 5'b00001, {112'hFFFF, 16'h00FF}, 16'hFFFF);
    checks++;
    if (out_result !== {112'h0, 16'h12CB, 16'h0003}) begin
      errors++; $display("FAIL xor_inactive_result: got %h want %h", out_result,
                         {112'h0, 16'h12CB, 16'h0003});
    end
    pop_result();
  endtask

  task automatic test_backpressure();
    logic [143:0] exp1;
    logic [143:0] exp2;
    exp1 = {64'h0, 64'h0123456789ABCDEF, 16'h00FF};
    exp2 = {120'h0, 8'h3C, 16'h0001};
    send_beat(1'b1, 1'b1, 2'b00, 5'b01000, {64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF},
              16'hFFFF);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold_cycle%0d: got ready=%b valid=%b want 0 1", c,
                           in_ready, out_valid);
      end
      checks++;
      if (out_result !== exp1) begin
        errors++; $display("FAIL bp_stable_cycle%0d: got %h want %h", c, out_result, exp1);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_first  = 1'b1;
    in_last   = 1'b1;
    in_op     = 2'b01;
    in_osize  = 5'b00001;
    in_result = {120'h0, 8'h3C, 16'hFFFF};
    in_valid  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_dual_handshake: got ready=%b valid=%b want 1 1",
                         in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== exp2) begin
      errors++; $display("FAIL bp_next_result: got valid=%b %h want 1 %h", out_valid,
                         out_result, exp2);
    end
    pop_result();
  endtask

  task automatic test_osize_zero();
    // osize 0 means 8-bit; reserved op 11 behaves as OR.
    send_beat(1'b1, 1'b0, 2'b11, 5'b00000, {112'h0, 16'hFFEE}, 16'hFFFF);
    send_beat(1'b0, 1'b1, 2'b00, 5'b00000, {112'h0, 16'h0011}, 16'hFFFF);
    checks++;
    if (out_result !== {120'h0, 8'hFF, 16'h0001}) begin
      errors++; $display("FAIL osize_zero_result: got %h want %h", out_result,
                         {120'h0, 8'hFF, 16'h0001});
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL osize_zero_no_err: got %b want 0", proto_err);
    end
    pop_result();
  endtask

  task automatic test_proto_restart();
    send_beat(1'b1, 1'b0, 2'b10, 5'b00001, {120'h0, 8'h11}, 16'hFFFF);
    send_beat(1'b1, 1'b0, 2'b01, 5'b00001, {120'h0, 8'h22}, 16'h0000);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL restart_proto_err: got %b want 1", proto_err);
    end
    send_beat(1'b0, 1'b1, 2'b01, 5'b00001, {120'h0, 8'h44}, 16'hFFFE);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 144'h0) begin
      errors++; $display("FAIL restart_all_inactive: got valid=%b %h want 1 0", out_valid,
                         out_result);
    end
    pop_result();
  endtask

  task automatic test_idle_nonfirst();
    do_reset();
    send_beat(1'b0, 1'b1, 2'b01, 5'b00001, {120'h0, 8'h77}, 16'hFFFF);
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_nonfirst: got err=%b busy=%b valid=%b want 1 0 0",
                         proto_err, busy, out_valid);
    end
  endtask

  task automatic test_rst_mid();
    logic [127:0] d;
    do_reset();
    send_beat(1'b1, 1'b0, 2'b00, 5'b00100, {96'h0, 32'hFFFFFFFF}, 16'hFFFF);
    send_beat(1'b0, 1'b0, 2'b00, 5'b00100, {96'h0, 32'h0000FFFF}, 16'hFFFF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 144'h0) begin
      errors++; $display("FAIL rst_mid: got busy=%b valid=%b %h want 0 0 0", busy, out_valid,
                         out_result);
    end
    d = 128'h0123456789ABCDEFFEDCBA9876543210;
    send_beat(1'b1, 1'b1, 2'b01, 5'b10000, d, 16'hFFFF);
    checks++;
    if (out_valid !== 1'b1 || out_result !== {d, 16'hFFFF}) begin
      errors++; $display("FAIL rst_fresh_w128: got valid=%b %h want 1 %h", out_valid,
                         out_result, {d, 16'hFFFF});
    end
    pop_result();
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_op     = 2'b00;
    in_osize  = 5'b00001;
    in_result = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_or();
    test_and4();
    test_xor_inactive();
    test_backpressure();
    test_osize_zero();
    test_proto_restart();
    test_idle_nonfirst();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
